paralelo_serial_tx: RTL and testbench
=====================================

Name: paralelo_serial_tx

Overview:
Per-lane TX serializer that drives the `data_paralelo_serial_N` wire consumed by the lane-N `serial_paralelo` receiver.
- Converts one byte per 8 `clk_32f` cycles into a bit stream, MSB first.
- Inserts the COM symbol whenever no valid byte is offered.
- After reset, forces a COM preamble so the receiver can lock before payload flows.
- One instance per lane, fed by the TX byte path at byte rate.

Parameters:
- COM_SYMBOL, 8'hBC, idle/alignment byte sent when no valid data.
- PREAMBLE_COMS, 4, number of COM bytes forced after reset before accepting data (legal 1..15).

Ports:
- clk_32f  input  1  bit-rate clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in_tx  input  8  byte to transmit; sampled only on a ready edge.
- valid_in_tx  input  1  data_in_tx holds a payload byte; sampled only on a ready edge.
- data_paralelo_serial  output  1  serial bit stream, MSB of each byte first.
- ready_out  output  1  high for exactly one cycle per byte slot; inputs are sampled on the rising edge that ends this cycle.
- active_out  output  1  high once the preamble has completed (state RUN).

Behaviour:
Registers:
- bit_cnt[2:0]
- shift_reg[7:0]
- pre_cnt[3:0]
- state (PREAMBLE, RUN)

Reset (asynchronous, immediate on assertion):
- bit_cnt=0, shift_reg=8'h00, pre_cnt=0, state=PREAMBLE.
- Outputs: data_paralelo_serial=0, ready_out=0, active_out=0.

Combinational outputs:
- data_paralelo_serial = shift_reg[7].
- ready_out = (bit_cnt==7) && (state==RUN).
- active_out = (state==RUN).

Every edge:
- bit_cnt increments mod 8.
- If bit_cnt!=7: shift_reg <= {shift_reg[6:0],1'b0}.

Load edge (bit_cnt==7):
- PREAMBLE:
  - shift_reg <= COM_SYMBOL; pre_cnt++.
  - If pre_cnt==PREAMBLE_COMS-1, state <= RUN; otherwise stay in PREAMBLE.
  - data_in_tx and valid_in_tx are ignored.
- RUN:
  - shift_reg <= valid_in_tx ? data_in_tx : COM_SYMBOL.
  - pre_cnt holds.

Timing, with edges numbered from the first rising edge after reset deassertion:
- Edges 1–7: output 0 (shift_reg all zeros).
- COM loads at edges 8, 16, …, 8·PREAMBLE_COMS.
- state becomes RUN at edge 8·PREAMBLE_COMS.
- First ready_out cycle: the cycle ending at edge 8·(PREAMBLE_COMS+1).
- Latency: a byte sampled at edge E drives bit7 in the cycle after E and bit0 in the cycle after E+7.

Boundary conditions:
- Back-to-back valid bytes produce a continuous stream with no gap bits.
- valid_in_tx low on a ready edge sends exactly one COM byte; there is no partial-byte idle.
- data_in_tx and valid_in_tx changes outside ready edges have no effect.
- A valid byte that equals COM_SYMBOL is transmitted unmodified; disambiguation is an upper-layer concern.
- Reset asserted mid-byte aborts the byte immediately, outputs 0, and the full preamble is repeated after deassertion.
- No backpressure beyond ready_out: an upstream that does not present a byte at the ready edge gets a COM.

Test Plan:
1. Reset, release, valid_in_tx=0, PREAMBLE_COMS=4:
   - data_paralelo_serial=0 for 8 cycles, then 4×10111100 (32 bits).
   - active_out rises at edge 32.
   - First ready_out is high in the cycle ending at edge 40 and never earlier.
2. After preamble, present 8'hA5 with valid_in_tx=1 at first ready edge, then valid_in_tx=0:
   - Serial stream 10100101, followed by 10111100 repeating.
   - ready_out high exactly every 8th cycle.
3. Back-to-back 8'h01, 8'hFF, 8'h80 on three consecutive ready edges:
   - Stream 00000001 11111111 10000000 with no gaps.
   - Receiver serial_paralelo reproduces the same bytes with valid high.
4. valid_in_tx=1, data_in_tx toggling between ready edges (e.g. 8'h3C mid-slot, 8'h5A at ready edge):
   - Only 8'h5A is transmitted.
5. Reset asserted at bit_cnt=3 of a payload byte:
   - Output drops to 0 immediately; ready_out=0; active_out=0.
   - After release, scenario-1 timing repeats exactly.
6. PREAMBLE_COMS=1:
   - Zeros for 8 cycles, one COM byte; active_out rises at edge 8.
   - First ready_out cycle ends at edge 16.

Source files
------------

// File: rtl/paralelo_serial_tx_if.sv
// paralelo_serial_tx_if: byte-side handshake and serial output of one TX lane
interface paralelo_serial_tx_if;
  logic [7:0] data_in_tx;
  logic valid_in_tx;
  logic data_paralelo_serial;
  logic ready_out;
  logic active_out;
  modport master(output data_in_tx, valid_in_tx, input data_paralelo_serial, ready_out, active_out);
  modport slave(input data_in_tx, valid_in_tx, output data_paralelo_serial, ready_out, active_out);
endinterface

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: per-lane byte serializer, MSB first, COM preamble after reset and COM fill when idle
module paralelo_serial_tx #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter int PREAMBLE_COMS = 4
) (
  input logic clk_32f,
  input logic reset,
  paralelo_serial_tx_if.slave bus
);
  typedef enum logic {PREAMBLE, RUN} state_t;
  state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [3:0] pre_cnt;
  // bit_cnt==7 is the load edge; payload is only taken once the preamble is done
  always_ff @(posedge clk_32f or posedge reset)
    if (reset) begin
      state <= PREAMBLE;
      bit_cnt <= 3'd0;
      shift_reg <= 8'h00;
      pre_cnt <= 4'd0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt != 3'd7) shift_reg <= {shift_reg[6:0], 1'b0};
      else if (state == PREAMBLE) begin
        shift_reg <= COM_SYMBOL;
        pre_cnt <= pre_cnt + 4'd1;
        if (pre_cnt == 4'(PREAMBLE_COMS - 1)) state <= RUN;
      end else shift_reg <= bus.valid_in_tx ? bus.data_in_tx : COM_SYMBOL;
    end
  assign bus.data_paralelo_serial = shift_reg[7];
  assign bus.ready_out = (bit_cnt == 3'd7) && (state == RUN);
  assign bus.active_out = (state == RUN);
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: two lanes (4-COM and 1-COM preamble) checked each cycle against a stream model
module tb_paralelo_serial_tx;
  localparam logic [7:0] COM = 8'hBC;
  logic clk_32f = 1'b0;
  logic reset = 1'b1;
  bit chk_en = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk_32f = ~clk_32f;
  paralelo_serial_tx_if bus[2] ();
  task automatic check(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int P = g == 0 ? 4 : 1;
    int k = 0;
    logic [7:0] sent [0:1023];
    paralelo_serial_tx #(.COM_SYMBOL(COM), .PREAMBLE_COMS(P)) dut (.clk_32f(clk_32f), .reset(reset), .bus(bus[g]));
    // stream since reset: one zero byte, P COM bytes, then one byte per ready edge
    function automatic logic bit_at(int kk);
      logic [7:0] v;
      v = kk < 8 ? 8'h00 : kk < 8 * (P + 1) ? COM : sent[kk / 8];
      return v[7 - kk % 8];
    endfunction
    always @(posedge clk_32f or posedge reset)
      if (reset) k <= 0;
      else begin
        if ((k + 1) % 8 == 0 && k + 1 >= 8 * (P + 1))
          sent[(k + 1) / 8] <= bus[g].valid_in_tx ? bus[g].data_in_tx : COM;
        k <= k + 1;
      end
    always @(negedge clk_32f)
      if (chk_en) begin
        if (reset) begin
          check($sformatf("lane%0d_rst_ser", g), 64'(bus[g].data_paralelo_serial), 64'd0);
          check($sformatf("lane%0d_rst_ready", g), 64'(bus[g].ready_out), 64'd0);
          check($sformatf("lane%0d_rst_active", g), 64'(bus[g].active_out), 64'd0);
        end else begin
          check($sformatf("lane%0d_ser_k%0d", g, k), 64'(bus[g].data_paralelo_serial), 64'(bit_at(k)));
          check($sformatf("lane%0d_ready_k%0d", g, k), 64'(bus[g].ready_out), 64'(k % 8 == 7 && k >= 8 * P + 7));
          check($sformatf("lane%0d_active_k%0d", g, k), 64'(bus[g].active_out), 64'(k >= 8 * P));
        end
      end
  end
  task automatic set(logic v, logic [7:0] d);
    bus[0].valid_in_tx = v;
    bus[0].data_in_tx = d;
    bus[1].valid_in_tx = v;
    bus[1].data_in_tx = d;
  endtask
  task automatic send(logic v, logic [7:0] d, logic mv, logic [7:0] md, output logic [7:0] got);
    set(v, d);
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_32f);
      got = {got[6:0], bus[0].data_paralelo_serial};
      if (i == 3) set(mv, md);
    end
  endtask
  task automatic preamble_check(string tag);
    logic [39:0] c0;
    logic [15:0] c1;
    int a0, r0, a1, r1;
    c0 = '0;
    c1 = '0;
    a0 = -1;
    r0 = -1;
    a1 = -1;
    r1 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_32f);
      c0 = {c0[38:0], bus[0].data_paralelo_serial};
      if (i < 16) c1 = {c1[14:0], bus[1].data_paralelo_serial};
      if (a0 < 0 && bus[0].active_out) a0 = i;
      if (r0 < 0 && bus[0].ready_out) r0 = i;
      if (a1 < 0 && bus[1].active_out) a1 = i;
      if (r1 < 0 && bus[1].ready_out) r1 = i;
    end
    check({tag, "_bits4"}, 64'(c0), 64'h00BCBCBCBC);
    check({tag, "_active4"}, 64'(a0), 64'd32);
    check({tag, "_ready4"}, 64'(r0), 64'd39);
    check({tag, "_bits1"}, 64'(c1), 64'h00BC);
    check({tag, "_active1"}, 64'(a1), 64'd8);
    check({tag, "_ready1"}, 64'(r1), 64'd15);
  endtask
  initial begin
    logic [7:0] got;
    set(1'b0, 8'h00);
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk_32f);
    #2 reset = 1'b0;
    preamble_check("run1");
    send(1'b1, 8'hA5, 1'b0, 8'h00, got);
    check("s2_a5", 64'(got), 64'hA5);
    send(1'b0, 8'h00, 1'b0, 8'h00, got);
    check("s2_idle_a", 64'(got), 64'hBC);
    send(1'b0, 8'h00, 1'b0, 8'h00, got);
    check("s2_idle_b", 64'(got), 64'hBC);
    send(1'b1, 8'h01, 1'b1, 8'h01, got);
    check("s3_01", 64'(got), 64'h01);
    send(1'b1, 8'hFF, 1'b1, 8'hFF, got);
    check("s3_ff", 64'(got), 64'hFF);
    send(1'b1, 8'h80, 1'b0, 8'h00, got);
    check("s3_80", 64'(got), 64'h80);
    send(1'b0, 8'h00, 1'b1, 8'h3C, got);
    check("s4_mid_ignored", 64'(got), 64'hBC);
    send(1'b1, 8'h5A, 1'b1, 8'h3C, got);
    check("s4_5a", 64'(got), 64'h5A);
    send(1'b1, COM, 1'b0, 8'h00, got);
    check("com_as_data", 64'(got), 64'hBC);
    set(1'b1, 8'hFF);
    repeat (4) @(negedge clk_32f);
    check("s5_pre_ser", 64'(bus[0].data_paralelo_serial), 64'd1);
    check("s5_pre_active", 64'(bus[0].active_out), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("s5_drop_ser", 64'(bus[0].data_paralelo_serial), 64'd0);
    check("s5_drop_ready", 64'(bus[0].ready_out), 64'd0);
    check("s5_drop_active", 64'(bus[0].active_out), 64'd0);
    set(1'b0, 8'h00);
    repeat (2) @(posedge clk_32f);
    #2 reset = 1'b0;
    preamble_check("run2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
